tlb_array: RTL and testbench
============================

Name: tlb_array

Overview:
- Fully associative LoongArch TLB that sits directly upstream of the address-translation MMU.
- Holds TLBNUM entries, each with a dual (even/odd) page. Entries are written and read by the TLBWR/TLBFILL/TLBRD path and cleared by INVTLB.
- Answers the MMU's single search port combinationally with found/ppn/ps/plv/mat/d/v.
- Also returns the hit index for TLBSRCH.

Parameters:
TLBNUM, 16, number of entries; must be a power of 2. IDXW = $clog2(TLBNUM) is a localparam.

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
s_vppn  input  19  search VA[31:13]
s_va_bit12  input  1  search VA[12]
s_asid  input  10  search ASID
s_found  output  1  search hit
s_index  output  IDXW  hit entry index
s_ppn  output  20  selected page PPN
s_ps  output  6  hit entry page size (12 or 21)
s_plv  output  2  selected page PLV
s_mat  output  2  selected page MAT
s_d  output  1  selected page dirty
s_v  output  1  selected page valid
we  input  1  write strobe
w_index  input  IDXW  write index
w_e  input  1  write entry exist bit
w_hi  input  36  {vppn[18:0], ps[5:0], asid[9:0], g}
w_lo0  input  26  even page {ppn[19:0], plv[1:0], mat[1:0], d, v}
w_lo1  input  26  odd page, same packing
r_index  input  IDXW  read index
r_e  output  1  read entry e bit
r_hi  output  36  read entry hi, packed as w_hi
r_lo0  output  26  read even page
r_lo1  output  26  read odd page
inv_en  input  1  INVTLB strobe
inv_op  input  5  INVTLB op code
inv_asid  input  10  INVTLB ASID operand
inv_vppn  input  19  INVTLB VA[31:13] operand

Behaviour:
- Storage is registers per entry: e, vppn, ps, asid, g, lo0, lo1.
- Asynchronous reset (resetn=0) clears every field of every entry to 0. All outputs are therefore 0 / not-found after reset.
- Write: at posedge clk with we=1, entry[w_index] takes w_e/w_hi/w_lo0/w_lo1. There is no write bypass; a search in the same cycle sees the old contents.
- Page-size rule: ps==21 means a 2MB page pair, and any other value is treated as 4KB. This rule applies to search, inv_op 5/6 matching, and page selection.
- vppn match for entry i:
  - ps==21: compare vppn[18:9].
  - otherwise: compare vppn[18:0].
- Search hit[i] = e[i] && (g[i] || asid[i]==s_asid) && vppn match.
- Search result:
  - s_found = |hit. s_index is the lowest hit index.
  - Odd-page select is s_vppn[8] when ps==21, else s_va_bit12.
  - s_ppn/plv/mat/d/v come from lo1 when the odd page is selected, else from lo0. s_ps is the entry ps.
  - Search is purely combinational, same-cycle.
  - On a miss, all s_* outputs are 0.
- Read: r_* = entry[r_index], combinational.
- INVTLB takes effect at posedge clk when inv_en=1. It clears the e bit only; other fields are retained.
  - op0, op1: all entries.
  - op2: g=1.
  - op3: g=0.
  - op4: g=0 && asid==inv_asid.
  - op5: g=0 && asid==inv_asid && vppn match against inv_vppn.
  - op6: (g=1 || asid==inv_asid) && vppn match against inv_vppn.
  - op7..31: no change. The illegal-op exception is raised by the pipeline, not here.
- Simultaneous we and inv_en in one cycle: invalidate is applied first, then the write. The written entry holds the written values even if it matched the invalidate.
- resetn asserted mid-operation overrides any pending write or invalidate.

Test Plan:
- Reset, then search vppn=0x00001, asid=0 -> s_found=0, all s_* outputs 0, r_e=0 for every index.
- Write idx3: e=1, vppn=0x12345, ps=12, asid=5, g=0, lo0.ppn=0xAAAAA, lo1.ppn=0xBBBBB, v=1, d=1. Same-cycle search -> miss. Next cycle, search vppn=0x12345, bit12=1, asid=5 -> found, index 3, ppn 0xBBBBB. With asid=6 -> miss.
- Write idx7: ps=21, vppn=0x40000, g=1, lo0.ppn=0x10000. Search vppn=0x400FF, bit8=0, any asid -> found, index 7, ppn 0x10000, ps 21.
- Write the same vppn/asid to idx2 and idx9 -> search returns s_index=2.
- With entries idx3 (g=0, asid 5) and idx7 (g=1): inv_op=4, asid=5 -> idx3 e=0, idx7 still hits. Then inv_op=2 -> idx7 e=0. Then inv_op=9 -> no change.
- Same-cycle inv_op=0 and write to idx1 (e=1) -> after the edge, r_e at idx1 is 1 and all other entries have e=0.

Source files
------------

// File: rtl/tlb_array_if.sv
// Bus bundle for tlb_array: MMU search port, TLBWR/TLBFILL write port,
// TLBRD read port and INVTLB command port.
interface tlb_array_if #(
  parameter int TLBNUM = 16
);
  localparam int IDXW = $clog2(TLBNUM);

  logic [18:0]     s_vppn;
  logic            s_va_bit12;
  logic [9:0]      s_asid;
  logic            s_found;
  logic [IDXW-1:0] s_index;
  logic [19:0]     s_ppn;
  logic [5:0]      s_ps;
  logic [1:0]      s_plv;
  logic [1:0]      s_mat;
  logic            s_d;
  logic            s_v;

  logic            we;
  logic [IDXW-1:0] w_index;
  logic            w_e;
  logic [35:0]     w_hi;
  logic [25:0]     w_lo0;
  logic [25:0]     w_lo1;

  logic [IDXW-1:0] r_index;
  logic            r_e;
  logic [35:0]     r_hi;
  logic [25:0]     r_lo0;
  logic [25:0]     r_lo1;

  logic            inv_en;
  logic [4:0]      inv_op;
  logic [9:0]      inv_asid;
  logic [18:0]     inv_vppn;

  modport master (
    output s_vppn, s_va_bit12, s_asid,
    input  s_found, s_index, s_ppn, s_ps, s_plv, s_mat, s_d, s_v,
    output we, w_index, w_e, w_hi, w_lo0, w_lo1,
    output r_index,
    input  r_e, r_hi, r_lo0, r_lo1,
    output inv_en, inv_op, inv_asid, inv_vppn
  );

  modport slave (
    input  s_vppn, s_va_bit12, s_asid,
    output s_found, s_index, s_ppn, s_ps, s_plv, s_mat, s_d, s_v,
    input  we, w_index, w_e, w_hi, w_lo0, w_lo1,
    input  r_index,
    output r_e, r_hi, r_lo0, r_lo1,
    input  inv_en, inv_op, inv_asid, inv_vppn
  );
endinterface

// File: rtl/tlb_array.sv
// Fully associative LoongArch TLB with dual even/odd pages per entry,
// combinational search/read and clocked write/INVTLB.
module tlb_array #(
  parameter int TLBNUM = 16
) (
  input  logic       clk,
  input  logic       resetn,
  tlb_array_if.slave bus
);
  localparam int IDXW = $clog2(TLBNUM);
  localparam logic [5:0] PS_2M = 6'd21;

  logic [TLBNUM-1:0] e_q, e_d;
  logic [TLBNUM-1:0] g_q, g_d;
  logic [18:0]       vppn_q [TLBNUM];
  logic [18:0]       vppn_d [TLBNUM];
  logic [5:0]        ps_q   [TLBNUM];
  logic [5:0]        ps_d   [TLBNUM];
  logic [9:0]        asid_q [TLBNUM];
  logic [9:0]        asid_d [TLBNUM];
  logic [25:0]       lo0_q  [TLBNUM];
  logic [25:0]       lo0_d  [TLBNUM];
  logic [25:0]       lo1_q  [TLBNUM];
  logic [25:0]       lo1_d  [TLBNUM];

  logic [TLBNUM-1:0] hit;
  logic [TLBNUM-1:0] inv_kill;
  logic [IDXW-1:0]   hit_idx;
  logic              found;
  logic              sel_odd;
  logic [25:0]       sel_lo;

  // A 2MB page pair ignores the low 9 vppn bits; anything else is a 4KB pair.
  function automatic logic vppn_match(input logic [5:0] ps, input logic [18:0] ev,
                                      input logic [18:0] v);
    logic m;
    if (ps == PS_2M) m = (ev[18:9] == v[18:9]);
    else             m = (ev == v);
    return m;
  endfunction

  function automatic logic inv_kill_f(input logic [4:0] op, input logic g,
                                      input logic asid_eq, input logic vm);
    logic k;
    k = 1'b0;
    case (op)
      5'd0, 5'd1: k = 1'b1;
      5'd2:       k = g;
      5'd3:       k = !g;
      5'd4:       k = !g && asid_eq;
      5'd5:       k = !g && asid_eq && vm;
      5'd6:       k = (g || asid_eq) && vm;
      default:    k = 1'b0;
    endcase
    return k;
  endfunction

  for (genvar gi = 0; gi < TLBNUM; gi++) begin : g_entry
    assign hit[gi] = e_q[gi] && (g_q[gi] || (asid_q[gi] == bus.s_asid)) &&
                     vppn_match(ps_q[gi], vppn_q[gi], bus.s_vppn);
    assign inv_kill[gi] = inv_kill_f(bus.inv_op, g_q[gi], asid_q[gi] == bus.inv_asid,
                                     vppn_match(ps_q[gi], vppn_q[gi], bus.inv_vppn));
  end

  // Descending scan so the lowest matching index wins.
  always_comb begin
    hit_idx = '0;
    found   = 1'b0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_idx = IDXW'(i);
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    sel_odd = (ps_q[hit_idx] == PS_2M) ? bus.s_vppn[8] : bus.s_va_bit12;
    sel_lo  = '0;
    if (found) sel_lo = sel_odd ? lo1_q[hit_idx] : lo0_q[hit_idx];
  end

  assign bus.s_found = found;
  assign bus.s_index = found ? hit_idx : '0;
  assign bus.s_ps    = found ? ps_q[hit_idx] : '0;
  assign bus.s_ppn   = sel_lo[25:6];
  assign bus.s_plv   = sel_lo[5:4];
  assign bus.s_mat   = sel_lo[3:2];
  assign bus.s_d     = sel_lo[1];
  assign bus.s_v     = sel_lo[0];

  assign bus.r_e   = e_q[bus.r_index];
  assign bus.r_hi  = {vppn_q[bus.r_index], ps_q[bus.r_index], asid_q[bus.r_index],
                      g_q[bus.r_index]};
  assign bus.r_lo0 = lo0_q[bus.r_index];
  assign bus.r_lo1 = lo1_q[bus.r_index];

  // Invalidate first, then the write overrides the targeted entry.
  always_comb begin
    for (int i = 0; i < TLBNUM; i++) begin
      e_d[i]    = e_q[i] && !(bus.inv_en && inv_kill[i]);
      g_d[i]    = g_q[i];
      vppn_d[i] = vppn_q[i];
      ps_d[i]   = ps_q[i];
      asid_d[i] = asid_q[i];
      lo0_d[i]  = lo0_q[i];
      lo1_d[i]  = lo1_q[i];
      if (bus.we && (bus.w_index == IDXW'(i))) begin
        e_d[i]    = bus.w_e;
        vppn_d[i] = bus.w_hi[35:17];
        ps_d[i]   = bus.w_hi[16:11];
        asid_d[i] = bus.w_hi[10:1];
        g_d[i]    = bus.w_hi[0];
        lo0_d[i]  = bus.w_lo0;
        lo1_d[i]  = bus.w_lo1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_q <= '0;
      g_q <= '0;
      for (int i = 0; i < TLBNUM; i++) begin
        vppn_q[i] <= '0;
        ps_q[i]   <= '0;
        asid_q[i] <= '0;
        lo0_q[i]  <= '0;
        lo1_q[i]  <= '0;
      end
    end else begin
      e_q <= e_d;
      g_q <= g_d;
      for (int i = 0; i < TLBNUM; i++) begin
        vppn_q[i] <= vppn_d[i];
        ps_q[i]   <= ps_d[i];
        asid_q[i] <= asid_d[i];
        lo0_q[i]  <= lo0_d[i];
        lo1_q[i]  <= lo1_d[i];
      end
    end
  end
endmodule

// File: tb/tb_tlb_array.sv
// Self-checking bench for tlb_array: directed scenarios with literal
// expectations plus randomized traffic against a VA-arithmetic model.
module tb_tlb_array;
  localparam int N = 16;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  tlb_array_if #(.TLBNUM(N)) bus ();

  tlb_array #(.TLBNUM(N)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit        m_e    [N];
  bit        m_g    [N];
  bit [18:0] m_vppn [N];
  bit [5:0]  m_ps   [N];
  bit [9:0]  m_asid [N];
  bit [25:0] m_lo0  [N];
  bit [25:0] m_lo1  [N];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Page size in address bits: 21 for a 2MB page, 12 for everything else.
  function automatic int page_bits(input bit [5:0] ps);
    return (ps == 6'd21) ? 21 : 12;
  endfunction

  // Same even/odd page pair: equal virtual address above the pair size.
  function automatic bit same_pair(input bit [5:0] ps, input bit [18:0] ev, input bit [31:0] va);
    bit [31:0] base;
    int sh;
    base = {ev, 13'b0};
    sh   = page_bits(ps) + 1;
    return (va >> sh) == (base >> sh);
  endfunction

  function automatic bit inv_rule(input int i, input bit [4:0] op, input bit [9:0] a,
                                  input bit [18:0] v);
    bit am, vm;
    am = (m_asid[i] == a);
    vm = same_pair(m_ps[i], m_vppn[i], {v, 13'b0});
    case (op)
      5'd0, 5'd1: return 1'b1;
      5'd2:       return m_g[i];
      5'd3:       return !m_g[i];
      5'd4:       return !m_g[i] && am;
      5'd5:       return !m_g[i] && am && vm;
      5'd6:       return (m_g[i] || am) && vm;
      default:    return 1'b0;
    endcase
  endfunction

  // Reference state update.
  initial begin : model
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        for (int i = 0; i < N; i++) begin
          m_e[i] = 0; m_g[i] = 0; m_vppn[i] = 0; m_ps[i] = 0;
          m_asid[i] = 0; m_lo0[i] = 0; m_lo1[i] = 0;
        end
      end else begin
        bit kill [N];
        for (int i = 0; i < N; i++)
          kill[i] = bus.inv_en && inv_rule(i, bus.inv_op, bus.inv_asid, bus.inv_vppn);
        for (int i = 0; i < N; i++) if (kill[i]) m_e[i] = 0;
        if (bus.we) begin
          m_e[bus.w_index]    = bus.w_e;
          m_vppn[bus.w_index] = bus.w_hi[35:17];
          m_ps[bus.w_index]   = bus.w_hi[16:11];
          m_asid[bus.w_index] = bus.w_hi[10:1];
          m_g[bus.w_index]    = bus.w_hi[0];
          m_lo0[bus.w_index]  = bus.w_lo0;
          m_lo1[bus.w_index]  = bus.w_lo1;
        end
      end
    end
  end

  // Every-cycle compare of search and read outputs against the model.
  initial begin : compare
    forever begin
      logic [36:0] exp_s, act_s;
      logic [88:0] exp_r, act_r;
      bit [31:0] va;
      bit [25:0] lo;
      bit        fnd;
      int        idx;
      @(negedge clk);
      va  = {bus.s_vppn, bus.s_va_bit12, 12'b0};
      fnd = 0;
      idx = 0;
      for (int i = 0; i < N; i++) begin
        if (!fnd && m_e[i] && (m_g[i] || m_asid[i] == bus.s_asid) &&
            same_pair(m_ps[i], m_vppn[i], va)) begin
          fnd = 1;
          idx = i;
        end
      end
      exp_s = '0;
      if (fnd) begin
        lo = ((va >> page_bits(m_ps[idx])) & 32'd1) != 0 ? m_lo1[idx] : m_lo0[idx];
        exp_s = {1'b1, 4'(idx), lo[25:6], m_ps[idx], lo[5:4], lo[3:2], lo[1], lo[0]};
      end
      act_s = {bus.s_found, bus.s_index, bus.s_ppn, bus.s_ps, bus.s_plv, bus.s_mat,
               bus.s_d, bus.s_v};
      chk("search", 128'(act_s), 128'(exp_s));
      exp_r = {m_e[bus.r_index], m_vppn[bus.r_index], m_ps[bus.r_index],
               m_asid[bus.r_index], m_g[bus.r_index], m_lo0[bus.r_index], m_lo1[bus.r_index]};
      act_r = {bus.r_e, bus.r_hi, bus.r_lo0, bus.r_lo1};
      chk("read", 128'(act_r), 128'(exp_r));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [25:0] mklo(input logic [19:0] ppn, input logic [1:0] plv,
                                       input logic [1:0] mat, input logic d, input logic v);
    return {ppn, plv, mat, d, v};
  endfunction

  task automatic set_write(input int idx, input logic e, input logic [18:0] vppn,
                           input logic [5:0] ps, input logic [9:0] asid, input logic g,
                           input logic [25:0] lo0, input logic [25:0] lo1);
    bus.we      = 1'b1;
    bus.w_index = 4'(idx);
    bus.w_e     = e;
    bus.w_hi    = {vppn, ps, asid, g};
    bus.w_lo0   = lo0;
    bus.w_lo1   = lo1;
  endtask

  task automatic set_search(input logic [18:0] vppn, input logic b12, input logic [9:0] asid);
    bus.s_vppn     = vppn;
    bus.s_va_bit12 = b12;
    bus.s_asid     = asid;
  endtask

  task automatic rand_cycle();
    logic [18:0] pool [4];
    logic [5:0]  ps;
    pool[0] = 19'h12345; pool[1] = 19'h40000; pool[2] = 19'h7FE00; pool[3] = 19'h00200;
    bus.we = ($urandom_range(0, 2) == 0);
    case ($urandom_range(0, 3))
      0, 1:    ps = 6'd12;
      2:       ps = 6'd21;
      default: ps = 6'($urandom);
    endcase
    set_write($urandom_range(0, N - 1), ($urandom_range(0, 3) != 0),
              pool[$urandom_range(0, 3)] ^ (($urandom_range(0, 3) == 0) ? 19'($urandom_range(0, 511)) : 19'd0),
              ps, 10'($urandom_range(0, 3)), 1'($urandom), 26'($urandom), 26'($urandom));
    bus.we       = ($urandom_range(0, 2) == 0);
    bus.inv_en   = ($urandom_range(0, 7) == 0);
    bus.inv_op   = 5'($urandom_range(0, 9));
    bus.inv_asid = 10'($urandom_range(0, 3));
    bus.inv_vppn = pool[$urandom_range(0, 3)] ^ 19'($urandom_range(0, 511));
    set_search(pool[$urandom_range(0, 3)] ^ (($urandom_range(0, 1) == 0) ? 19'($urandom_range(0, 511)) : 19'd0),
               1'($urandom), 10'($urandom_range(0, 3)));
    bus.r_index = 4'($urandom_range(0, N - 1));
  endtask

  initial begin : main
    checks = 0;
    errors = 0;
    resetn = 1'b1;
    bus.we = 0; bus.w_index = '0; bus.w_e = 0; bus.w_hi = '0; bus.w_lo0 = '0; bus.w_lo1 = '0;
    bus.r_index = '0; bus.inv_en = 0; bus.inv_op = '0; bus.inv_asid = '0; bus.inv_vppn = '0;
    set_search(19'h00001, 1'b0, 10'd0);
    #1 resetn = 1'b0;
    repeat (3) step();
    resetn = 1'b1;
    #2;
    chk("reset_found", 128'(bus.s_found), 128'(0));
    chk("reset_search_all", 128'({bus.s_index, bus.s_ppn, bus.s_ps, bus.s_plv, bus.s_mat,
                                  bus.s_d, bus.s_v}), 128'(0));
    for (int i = 0; i < N; i++) begin
      bus.r_index = 4'(i);
      #1;
      chk("reset_r_e", 128'(bus.r_e), 128'(0));
    end

    // idx3, 4KB pair, asid 5; same-cycle search still misses
    step();
    set_write(3, 1, 19'h12345, 6'd12, 10'd5, 0, mklo(20'hAAAAA, 0, 0, 1, 1),
              mklo(20'hBBBBB, 0, 0, 1, 1));
    set_search(19'h12345, 1'b1, 10'd5);
    #2;
    chk("no_bypass", 128'(bus.s_found), 128'(0));
    step();
    bus.we = 0;
    #2;
    chk("idx3_found", 128'(bus.s_found), 128'(1));
    chk("idx3_index", 128'(bus.s_index), 128'(3));
    chk("idx3_ppn", 128'(bus.s_ppn), 128'(20'hBBBBB));
    bus.s_asid = 10'd6;
    #1;
    chk("asid_miss", 128'(bus.s_found), 128'(0));

    // idx7, global 2MB pair
    step();
    set_write(7, 1, 19'h40000, 6'd21, 10'd0, 1, mklo(20'h10000, 0, 0, 0, 1),
              mklo(20'h10200, 0, 0, 0, 1));
    step();
    bus.we = 0;
    set_search(19'h400FF, 1'b0, 10'h3A7);
    #2;
    chk("idx7_found", 128'(bus.s_found), 128'(1));
    chk("idx7_index", 128'(bus.s_index), 128'(7));
    chk("idx7_ppn", 128'(bus.s_ppn), 128'(20'h10000));
    chk("idx7_ps", 128'(bus.s_ps), 128'(21));

    // duplicate translations: lowest index wins
    step();
    set_write(2, 1, 19'h12345, 6'd12, 10'd5, 0, mklo(20'h22222, 1, 1, 0, 1), mklo(20'h22223, 0, 0, 0, 1));
    step();
    set_write(9, 1, 19'h12345, 6'd12, 10'd5, 0, mklo(20'h99999, 0, 0, 0, 1), mklo(20'h99998, 0, 0, 0, 1));
    step();
    bus.we = 0;
    set_search(19'h12345, 1'b0, 10'd5);
    #2;
    chk("dup_index", 128'(bus.s_index), 128'(2));
    chk("dup_ppn", 128'(bus.s_ppn), 128'(20'h22222));

    // op4 asid 5 clears non-global asid-5 entries only
    step();
    bus.inv_en = 1; bus.inv_op = 5'd4; bus.inv_asid = 10'd5;
    step();
    bus.inv_en = 0;
    bus.r_index = 4'd3;
    #2;
    chk("op4_idx3_e", 128'(bus.r_e), 128'(0));
    chk("op4_idx3_miss", 128'(bus.s_found), 128'(0));
    set_search(19'h400FF, 1'b0, 10'h3A7);
    #1;
    chk("op4_idx7_hit", 128'(bus.s_index), 128'(7));
    step();
    bus.inv_en = 1; bus.inv_op = 5'd2;
    step();
    bus.inv_en = 0;
    bus.r_index = 4'd7;
    #2;
    chk("op2_idx7_e", 128'(bus.r_e), 128'(0));

    // op9 leaves entries untouched
    step();
    set_write(5, 1, 19'h00055, 6'd12, 10'd1, 1, '0, '0);
    step();
    bus.we = 0;
    bus.inv_en = 1; bus.inv_op = 5'd9;
    step();
    bus.inv_en = 0;
    bus.r_index = 4'd5;
    #2;
    chk("op9_idx5_e", 128'(bus.r_e), 128'(1));

    // invalidate-all together with a write: the write survives
    step();
    bus.inv_en = 1; bus.inv_op = 5'd0;
    set_write(1, 1, 19'h00011, 6'd12, 10'd2, 0, '0, '0);
    step();
    bus.inv_en = 0; bus.we = 0;
    for (int i = 0; i < N; i++) begin
      bus.r_index = 4'(i);
      #1;
      chk("inv_wr_r_e", 128'(bus.r_e), 128'(i == 1));
    end

    step();
    for (int c = 0; c < 3000; c++) begin
      rand_cycle();
      if (c == 1500) begin
        bus.we = 1;
        resetn = 1'b0;
        step();
        resetn = 1'b1;
      end else begin
        step();
      end
    end
    bus.we = 0; bus.inv_en = 0;
    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
